// File: rtl/div_pkg.sv
// div_pkg: shared width defaults and FSM state encoding for the divider operand stage.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_SHW   = 5;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        ZERO  = 3'd4
    } state_t;
endpackage

// File: rtl/div_norm_step.sv
// div_norm_step: one combinational normalization step of the divisor.
// DIV_NORM_FAST_EN skips a whole zero nibble at once; otherwise one bit per step.
module div_norm_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int SHW   = DIV_SHW
) (
    input  logic [WIDTH-1:0] nb,
    output logic [WIDTH-1:0] nb_next,
    output logic [SHW-1:0]   inc
);
`ifdef DIV_NORM_FAST_EN
    logic nib_zero;
    assign nib_zero = nb[WIDTH-1 -: 4] == 4'd0;
    assign nb_next  = nib_zero ? nb << 4 : nb << 1;
    assign inc      = nib_zero ? SHW'(4) : SHW'(1);
`else
    assign nb_next = nb << 1;
    assign inc     = SHW'(1);
`endif
endmodule

// File: rtl/div_norm_stage.sv
// div_norm_stage: normalizes the divisor, issues a start to the divider and traps divide-by-zero.
// Optional DIV_NORM_FAST_EN (in div_norm_step) shifts four bits per cycle across zero nibbles.
module div_norm_stage import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int SHW   = DIV_SHW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             div_busy,
    input  logic             div_ready,
    output logic [WIDTH-1:0] na,
    output logic [WIDTH-1:0] nb,
    output logic [SHW-1:0]   sh,
    output logic             start,
    output logic             dz,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] step_nb;
    logic [SHW-1:0]   step_inc;

    div_norm_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
        .nb      (nb),
        .nb_next (step_nb),
        .inc     (step_inc)
    );

    assign in_ready = state == IDLE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            na    <= '0;
            nb    <= '0;
            sh    <= '0;
            start <= 1'b0;
            dz    <= 1'b0;
            done  <= 1'b0;
        end else begin
            start <= 1'b0;
            dz    <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    na <= a;
                    nb <= b;
                    sh <= '0;
                    dz <= b == '0;
                    state <= b == '0 ? ZERO : b[WIDTH-1] ? ISSUE : SHIFT;
                end
                // leave as soon as the value being written has its MSB set
                SHIFT: begin
                    nb <= step_nb;
                    sh <= sh + step_inc;
                    if (step_nb[WIDTH-1]) state <= ISSUE;
                end
                ISSUE: if (!div_busy) begin
                    start <= 1'b1;
                    state <= WAIT;
                end
                WAIT: if (div_ready) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
